// File: rtl/misalign_lsu.sv
// misalign_lsu: splits misaligned halfword/word accesses into byte accesses and reassembles load data
module misalign_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic        ExtSign,
  input  logic [1:0]  MemSize,
  input  logic [31:0] addr,
  input  logic [31:0] WD,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        mem_WE,
  output logic        mem_ExtSign,
  output logic [1:0]  mem_MemSize,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_read
);
  typedef enum logic {IDLE, SPLIT} state_t;
  state_t      state, state_n;
  logic [1:0]  cnt, cnt_n;
  logic [23:0] acc, acc_n;
  logic        mis, last;
  logic [7:0]  wd_byte, rd_byte;
  logic [31:0] assembled;
  assign mis     = (MemSize == 2'b01 && addr[0]) || (MemSize == 2'b10 && addr[1:0] != 2'b00);
  assign last    = (MemSize == 2'b01) ? cnt == 2'd1 : cnt == 2'd3;
  assign wd_byte = WD[{cnt, 3'b000} +: 8];
  assign rd_byte = mem_read[7:0];
  // final byte arrives from memory this cycle; earlier bytes come from acc
  assign assembled = (MemSize == 2'b01) ? {{16{ExtSign & rd_byte[7]}}, rd_byte, acc[7:0]}
                                        : {rd_byte, acc};
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    acc_n       = acc;
    stall       = 1'b0;
    rdata       = 32'h0;
    mem_WE      = WE & req;
    mem_ExtSign = ExtSign;
    mem_MemSize = MemSize;
    mem_addr    = addr;
    mem_WD      = WD;
    if (state == IDLE) begin
      if (req && !mis) begin
        rdata = mem_read;
      end else if (req) begin
        mem_MemSize = 2'b00;
        mem_ExtSign = 1'b0;
        mem_WD      = {24'h0, WD[7:0]};
        stall       = 1'b1;
        acc_n[7:0]  = rd_byte;
        state_n     = SPLIT;
        cnt_n       = 2'd1;
      end
    end else begin
      mem_MemSize = 2'b00;
      mem_ExtSign = 1'b0;
      mem_addr    = addr + {30'h0, cnt};
      mem_WD      = {24'h0, wd_byte};
      if (!req) begin
        state_n = IDLE;
        cnt_n   = 2'd0;
      end else if (!last) begin
        stall = 1'b1;
        if (cnt == 2'd1) acc_n[15:8] = rd_byte;
        else acc_n[23:16] = rd_byte;
        cnt_n = cnt + 2'd1;
      end else begin
        rdata   = WE ? 32'h0 : assembled;
        state_n = IDLE;
        cnt_n   = 2'd0;
      end
    end
    if (rst) begin
      mem_WE = 1'b0;
      stall  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 2'd0;
      acc   <= 24'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      acc   <= acc_n;
    end
  end
endmodule

// File: tb/tb_misalign_lsu.sv
// tb_misalign_lsu: random and directed loads/stores against a byte-array reference model
module tb_misalign_lsu;
  logic        clk = 0, rst = 1, req = 0, WE = 0, ExtSign = 0;
  logic [1:0]  MemSize = 0;
  logic [31:0] addr = 0, WD = 0;
  logic        stall, mem_WE, mem_ExtSign;
  logic [1:0]  mem_MemSize;
  logic [31:0] rdata, mem_addr, mem_WD, mem_read, dw;
  int          n_vec = 0, n_err = 0;
  logic [7:0]  dmem [256];
  logic [7:0]  ref_mem [256];
  logic        init_done = 0, pl_en = 0;
  logic [7:0]  pl_a = 0, pl_d = 0;
  int          e_mode = 0;
  logic        e_stall, e_we, e_ext;
  logic [1:0]  e_size;
  logic [31:0] e_addr, e_wd, e_rd, last_rdata;
  bit          obs_stall [$];
  logic [31:0] obs_addr [$];

  always #5 clk = ~clk;

  misalign_lsu dut (
    .clk(clk), .rst(rst), .req(req), .WE(WE), .ExtSign(ExtSign), .MemSize(MemSize),
    .addr(addr), .WD(WD), .stall(stall), .rdata(rdata), .mem_WE(mem_WE),
    .mem_ExtSign(mem_ExtSign), .mem_MemSize(mem_MemSize), .mem_addr(mem_addr),
    .mem_WD(mem_WD), .mem_read(mem_read)
  );

  always_comb begin
    dw = {dmem[mem_addr[7:0] + 8'd3], dmem[mem_addr[7:0] + 8'd2],
          dmem[mem_addr[7:0] + 8'd1], dmem[mem_addr[7:0]]};
    mem_read = mem_MemSize == 2'b00 ? {{24{mem_ExtSign & dw[7]}}, dw[7:0]} :
               mem_MemSize == 2'b01 ? {{16{mem_ExtSign & dw[15]}}, dw[15:0]} :
               mem_MemSize == 2'b10 ? dw : 32'h0;
  end

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'(i * 37 + 11);
      init_done <= 1;
    end else begin
      if (mem_WE)
        for (int i = 0; i < (mem_MemSize == 2'b00 ? 1 : mem_MemSize == 2'b01 ? 2 : mem_MemSize == 2'b10 ? 4 : 0); i++)
          dmem[mem_addr[7:0] + 8'(i)] <= mem_WD[8*i +: 8];
      if (pl_en) dmem[pl_a] <= pl_d;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input logic [31:0] a, input logic [1:0] sz, input logic ex);
    logic [31:0] w;
    w = {ref_mem[a[7:0] + 8'd3], ref_mem[a[7:0] + 8'd2], ref_mem[a[7:0] + 8'd1], ref_mem[a[7:0]]};
    case (sz)
      2'b00:   return {{24{ex & w[7]}}, w[7:0]};
      2'b01:   return {{16{ex & w[15]}}, w[15:0]};
      2'b10:   return w;
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (e_mode >= 1) check("mem_WE", {31'h0, mem_WE}, {31'h0, e_we});
    if (e_mode >= 2) check("stall", {31'h0, stall}, {31'h0, e_stall});
    if (e_mode == 3) begin
      check("mem_ExtSign", {31'h0, mem_ExtSign}, {31'h0, e_ext});
      check("mem_MemSize", {30'h0, mem_MemSize}, {30'h0, e_size});
      check("mem_addr", mem_addr, e_addr);
      check("mem_WD", mem_WD, e_wd);
      check("rdata", rdata, e_rd);
    end
    obs_stall.push_back(stall);
    obs_addr.push_back(mem_addr);
    last_rdata = rdata;
  end

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      req = 0; WE = 1'($urandom); ExtSign = 1'($urandom); MemSize = 2'($urandom);
      addr = $urandom; WD = $urandom;
      e_mode = 3; e_stall = 0; e_we = 0; e_ext = ExtSign; e_size = MemSize;
      e_addr = addr; e_wd = WD; e_rd = 0;
    end
  endtask

  task automatic txn(input bit we, input bit ex, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bit mis;
    int n;
    mis = (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    n = mis ? (sz == 2'b01 ? 2 : 4) : 1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin obs_stall.delete(); obs_addr.delete(); end
      req = 1; WE = we; ExtSign = ex; MemSize = sz; addr = a; WD = wd;
      e_mode = 3; e_stall = k < n - 1; e_we = we;
      if (!mis) begin
        e_ext = ex; e_size = sz; e_addr = a; e_wd = wd; e_rd = mread(a, sz, ex);
      end else begin
        e_ext = 0; e_size = 0; e_addr = a + k; e_wd = {24'h0, wd[8*k +: 8]};
        e_rd = (k == n - 1 && !we) ? mread(a, sz, ex) : 32'h0;
      end
    end
    if (we)
      for (int i = 0; i < (sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : sz == 2'b10 ? 4 : 0); i++)
        ref_mem[a[7:0] + 8'(i)] = wd[8*i +: 8];
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] stall_seq();
    logic [31:0] s = 0;
    foreach (obs_stall[i]) s = {s[30:0], obs_stall[i]};
    return s;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    req = 1; WE = 1; MemSize = 2'b10; addr = 32'h1; WD = 32'h12345678;
    e_mode = 2; e_stall = 0; e_we = 0;
    repeat (2) @(posedge clk);
    #1 req = 0; rst = 0;
    idle(2);

    txn(1, 0, 2'b10, 32'h8, 32'hDEADBEEF);
    check("sw8_stall_seq", stall_seq(), 32'h0);
    txn(0, 0, 2'b10, 32'h8, 32'h0);
    check("lw8_readback", last_rdata, 32'hDEADBEEF);

    txn(1, 0, 2'b10, 32'h5, 32'hAABBCCDD);
    check("sw5_stall_seq", stall_seq(), 32'b1110);
    check("sw5_addr3", obs_addr[3], 32'h8);
    txn(0, 0, 2'b10, 32'h5, 32'h0);
    check("lw5_rdata", last_rdata, 32'hAABBCCDD);

    pl_en = 1; pl_a = 8'h3; pl_d = 8'h34; ref_mem[3] = 8'h34;
    idle(1);
    pl_a = 8'h4; pl_d = 8'h92; ref_mem[4] = 8'h92;
    idle(1);
    pl_en = 0;
    txn(0, 1, 2'b01, 32'h3, 32'h0);
    check("lh3_rdata", last_rdata, 32'hFFFF9234);
    check("lh3_stall_seq", stall_seq(), 32'b10);
    txn(0, 0, 2'b01, 32'h3, 32'h0);
    check("lhu3_rdata", last_rdata, 32'h00009234);

    txn(0, 0, 2'b10, 32'hFFFFFFFF, 32'h0);
    check("wrap_addr0", obs_addr[0], 32'hFFFFFFFF);
    check("wrap_addr1", obs_addr[1], 32'h0);
    check("wrap_addr2", obs_addr[2], 32'h1);
    check("wrap_addr3", obs_addr[3], 32'h2);
    check("wrap_stall_seq", stall_seq(), 32'b1110);

    @(posedge clk); #1;
    req = 1; WE = 1; ExtSign = 0; MemSize = 2'b10; addr = 32'h1; WD = 32'h11223344;
    e_mode = 3; e_stall = 1; e_we = 1; e_ext = 0; e_size = 0; e_addr = 32'h1; e_wd = 32'h44; e_rd = 0;
    ref_mem[1] = 8'h44;
    @(posedge clk); #1;
    rst = 1; e_mode = 2; e_stall = 0; e_we = 0;
    @(posedge clk); #1;
    rst = 0; req = 0;
    txn(0, 0, 2'b10, 32'h0, 32'h0);
    check("post_rst_stall_seq", stall_seq(), 32'h0);
    check("post_rst_byte1", {24'h0, last_rdata[15:8]}, 32'h44);
    check("post_rst_byte2", {24'h0, last_rdata[23:16]}, {24'h0, 8'(2 * 37 + 11)});

    txn(1, 0, 2'b00, 32'h3, 32'h55);
    check("sb3_stall_seq", stall_seq(), 32'h0);
    txn(1, 0, 2'b11, 32'h6, 32'hFFFF_FFFF);
    check("inv_stall_seq", stall_seq(), 32'h0);
    idle(3);
    check("idle_rdata", last_rdata, 32'h0);

    @(posedge clk); #1;
    req = 1; WE = 1; ExtSign = 0; MemSize = 2'b10; addr = 32'h21; WD = 32'hCAFEF00D;
    e_mode = 3; e_stall = 1; e_we = 1; e_ext = 0; e_size = 0; e_addr = 32'h21; e_wd = 32'h0D; e_rd = 0;
    ref_mem[8'h21] = 8'h0D;
    @(posedge clk); #1;
    req = 0; e_mode = 1; e_we = 0;
    txn(0, 0, 2'b10, 32'h20, 32'h0);
    check("drop_byte1", {24'h0, last_rdata[15:8]}, 32'h0D);
    check("drop_byte2", {24'h0, last_rdata[23:16]}, {24'h0, 8'(8'h22 * 37 + 11)});

    repeat (400) begin
      idle($urandom_range(0, 2));
      txn(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), $urandom, $urandom);
    end
    for (int i = 0; i < 64; i++) txn(0, 0, 2'b10, 32'(i * 4), 32'h0);

    @(posedge clk); #1 e_mode = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
